wormhole_out_sched: RTL and testbench
=====================================

WORMHOLE_OUT_SCHED -- requirements
Module: wormhole_out_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of input requesters (legal range 2..8).
REQ-002 The block SHALL have parameter CREDITS, default 4, giving the downstream buffer depth in flits (legal range 1..15).
REQ-003 Port clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port arst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-005 Port req_i  input  N_REQ  bit i high: input i presents a valid flit this cycle.
REQ-006 Port tail_i  input  N_REQ  bit i high: the flit on input i is a tail flit; single-flit packets assert both head and tail.
REQ-007 Port credit_i  input  1  one-cycle pulse: downstream returns one buffer credit.
REQ-008 Port grant_o  output  N_REQ  one-hot or zero; bit i high: the flit of input i transfers this cycle.
REQ-009 Port fire_o  output  1  OR-reduction of grant_o.
REQ-010 Port credits_o  output  4  current credit count.
REQ-011 Port busy_o  output  1  high while a multi-flit packet holds the output.
REQ-012 Port err_o  output  1  sticky credit-overflow flag.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and LOCKED, plus a round-robin pointer ptr (0..N_REQ-1), an owner register, and a credit counter.
REQ-014 grant_o SHALL be combinational from the current state, req_i, ptr, owner and credits, with zero-cycle latency.
REQ-015 No grant SHALL be issued in any cycle in which credits equals 0.
REQ-016 In IDLE with credits > 0, the winner SHALL be the first requesting index at or after ptr, searching upward with wrap-around from N_REQ-1 to 0.
REQ-017 In IDLE, if the winner's tail_i bit is 1, the FSM SHALL stay in IDLE and ptr SHALL become (winner+1) mod N_REQ.
REQ-018 In IDLE, if the winner's tail_i bit is 0, the FSM SHALL enter LOCKED, owner SHALL take the winner index, and ptr SHALL remain unchanged.
REQ-019 In LOCKED, grant_o[owner] SHALL equal req_i[owner] AND (credits > 0), and every other grant bit SHALL be 0 regardless of req_i.
REQ-020 In LOCKED, a granted flit with tail_i[owner]=1 SHALL return the FSM to IDLE and set ptr to (owner+1) mod N_REQ; a new arbitration SHALL first occur the following cycle.
REQ-021 In LOCKED, a cycle in which req_i[owner]=0 is a bubble: no grant is issued, and the FSM and owner are unchanged.
REQ-022 busy_o SHALL be high exactly when the state is LOCKED.
REQ-023 The credit counter SHALL decrement by 1 on fire_o, increment by 1 on credit_i, and stay unchanged when both occur in the same cycle.
REQ-024 A credit_i pulse while credits equals CREDITS and fire_o=0 SHALL leave the count at CREDITS (saturating) and set err_o, which stays set until reset.
REQ-025 The credit counter SHALL never underflow; REQ-015 guarantees this.
REQ-026 ptr SHALL change only on tail-flit transfers.

Reset
REQ-027 While arst=0, the state SHALL be IDLE, ptr=0, owner=0, credits=CREDITS, and err_o=0, asynchronously and independent of clk.
REQ-028 While arst=0, grant_o, fire_o and busy_o SHALL be 0.
REQ-029 Reset asserted mid-packet SHALL abandon the lock; after release, arbitration SHALL restart from index 0 with full credits.
REQ-030 Reset release SHALL be clean on any clk edge; the first grant may occur in the first cycle after release.

Verification
REQ-031 Defaults, after reset: req_i=4'b1111, all tails=1, credit_i returned every cycle -> grants 0001, 0010, 0100, 1000, 0001 in consecutive cycles.
REQ-032 Defaults: input 2 sends a 3-flit packet (tails 0,0,1) while req_i=4'b1111 -> grant_o=0100 for 3 cycles with busy_o=1 on cycles 2-3, then the next grant goes to input 3.
REQ-033 Defaults: no credit_i, req_i[0] held with tail=1 -> exactly 4 grants, credits_o steps 4,3,2,1,0, then grant_o=0; one credit_i pulse -> exactly one further grant.
REQ-034 Defaults: LOCKED on input 1 with req_i[1]=0 for 2 cycles and req_i[3]=1 -> grant_o=0000 for those cycles, busy_o stays 1, and input 3 receives no grant.
REQ-035 Defaults: credits_o=4 and credit_i=1 with no fire -> credits_o stays 4 and err_o=1 persists until arst=0.
REQ-036 Defaults: arst driven to 0 mid-packet on input 2, then released -> busy_o=0, credits_o=4, and with req_i=4'b1111 the first grant is 0001.

Source files
------------

// File: rtl/wormhole_out_sched.sv
// Output-port scheduler for a wormhole router: round-robin arbitration among
// N_REQ inputs, packet locking until the tail flit, and downstream credit tracking.
module wormhole_out_sched #(
  parameter int N_REQ   = 4,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] tail_i,
  input  logic             credit_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             fire_o,
  output logic [3:0]       credits_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      credits_q, credits_d;
  logic            err_q, err_d;

  logic [N_REQ-1:0] grant_s;
  logic [PW-1:0]    win_s;
  logic             found_s;
  logic [PW:0]      cand_s;
  logic             fire_s;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    logic [PW:0] sum;
    sum = {1'b0, idx} + PW1'(1);
    if (sum >= PW1'(N_REQ)) begin
      next_idx = {PW{1'b0}};
    end else begin
      next_idx = sum[PW-1:0];
    end
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping to 0.
  always_comb begin
    found_s = 1'b0;
    win_s   = {PW{1'b0}};
    cand_s  = {PW1{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_q} + PW1'(i);
      if (cand_s >= PW1'(N_REQ)) begin
        cand_s = cand_s - PW1'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[PW-1:0]]) begin
        found_s = 1'b1;
        win_s   = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // FSM next state, pointer/owner update and grant generation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_s = {N_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if ((credits_q != 4'd0) && found_s) begin
          grant_s[win_s] = 1'b1;
          if (tail_i[win_s]) begin
            ptr_d = next_idx(win_s);
          end else begin
            state_d = LOCKED;
            owner_d = win_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        // A missing owner flit is a bubble; the lock is held regardless.
        if ((credits_q != 4'd0) && req_i[owner_q]) begin
          grant_s[owner_q] = 1'b1;
          if (tail_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = next_idx(owner_q);
          end else begin
            state_d = LOCKED;
          end
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant_o = grant_s & {N_REQ{arst}};
  assign fire_s  = |grant_o;
  assign fire_o  = fire_s;

  // Credit accounting with saturation and sticky overflow flag.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({fire_s, credit_i})
      2'b10: begin
        credits_d = credits_q - 4'd1;
      end
      2'b01: begin
        if (credits_q >= CRED_MAX) begin
          err_d = 1'b1;
        end else begin
          credits_d = credits_q + 4'd1;
        end
      end
      default: begin
        credits_d = credits_q;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= IDLE;
      ptr_q     <= {PW{1'b0}};
      owner_q   <= {PW{1'b0}};
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits_o = credits_q;
  assign busy_o    = (state_q == LOCKED);
  assign err_o     = err_q;

endmodule

// File: tb/tb_wormhole_out_sched.sv
// Scoreboard bench for wormhole_out_sched: a packet-level reference model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_wormhole_out_sched;

  localparam int N   = 4;
  localparam int CR  = 4;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] tail_i = '0;
  logic         credit_i = 1'b0;
  logic [N-1:0] grant_o;
  logic         fire_o;
  logic [3:0]   credits_o;
  logic         busy_o;
  logic         err_o;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         fire;
    logic [3:0]   credits;
    logic         busy;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  wormhole_out_sched #(.N_REQ(N), .CREDITS(CR)) dut (
    .clk(clk), .arst(arst), .req_i(req_i), .tail_i(tail_i), .credit_i(credit_i),
    .grant_o(grant_o), .fire_o(fire_o), .credits_o(credits_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cred   = CR;
    m_err    = 1'b0;
  endtask

  // Drive one cycle of inputs, predict outputs, then advance the model one edge.
  task automatic step(input logic rstn, input logic [N-1:0] req,
                      input logic [N-1:0] tail, input logic cr);
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    arst = rstn; req_i = req; tail_i = tail; credit_i = cr;
    cyc++;
    if (!rstn) begin
      model_reset();
      e = '{grant: '0, fire: 1'b0, credits: 4'(CR), busy: 1'b0, err: 1'b0};
      exp_q.push_back(e);
      return;
    end
    g = -1;
    if (m_cred > 0) begin
      if (m_locked) begin
        if (req[m_owner]) g = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (g < 0 && req[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        end
      end
    end
    e.grant   = (g >= 0) ? N'(1 << g) : '0;
    e.fire    = (g >= 0);
    e.credits = 4'(m_cred);
    e.busy    = m_locked;
    e.err     = m_err;
    exp_q.push_back(e);
    if (g >= 0) begin
      if (tail[g]) begin
        m_locked = 1'b0;
        m_ptr    = (g + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
    if (g >= 0 && !cr) m_cred--;
    else if (g < 0 && cr) begin
      if (m_cred == CR) m_err = 1'b1;
      else m_cred++;
    end
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
  endtask

  // Monitor: pop the prediction for this cycle and compare every output.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("grant",   int'(grant_o),   int'(e.grant));
      cmp("fire",    int'(fire_o),    int'(e.fire));
      cmp("credits", int'(credits_o), int'(e.credits));
      cmp("busy",    int'(busy_o),    int'(e.busy));
      cmp("err",     int'(err_o),     int'(e.err));
    end
  end

  initial begin
    model_reset();
    repeat (2) step(1'b0, 4'b0000, 4'b0000, 1'b0);
    // round robin with all tails and continuous credit return
    repeat (6) step(1'b1, 4'b1111, 4'b1111, 1'b1);
    // three-flit packet on input 2 while everyone requests
    repeat (2) step(1'b1, 4'b1111, 4'b1011, 1'b1);
    repeat (3) step(1'b1, 4'b1111, 4'b1111, 1'b1);
    // credit exhaustion and single refill
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (6) step(1'b1, 4'b0001, 4'b1111, 1'b0);
    step(1'b1, 4'b0001, 4'b1111, 1'b1);
    repeat (3) step(1'b1, 4'b0001, 4'b1111, 1'b0);
    // bubbles while locked on input 1, input 3 must wait
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 1'b0);
    repeat (2) step(1'b1, 4'b1000, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, 4'b0010, 1'b1);
    step(1'b1, 4'b1010, 4'b1010, 1'b1);
    // credit overflow makes err sticky until reset
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    repeat (3) step(1'b1, 4'b0011, 4'b1111, 1'b0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    // reset mid-packet on input 2, then restart from index 0
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    repeat (3) step(1'b1, 4'b1111, 4'b1111, 1'b0);
    // randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) != 0), N'($urandom), N'($urandom),
           ($urandom_range(0, 2) == 0));
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain actual=%0d required=0 pending predictions", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
